// File: rtl/ospe_pkg.sv
// Shared widths and array-level types for the output-stationary PE.
package ospe_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ACC_W_DEF  = 32;

   typedef logic [DATA_W_DEF-1:0] data_t;
   typedef logic [ACC_W_DEF-1:0]  acc_t;

endpackage

// File: rtl/ospe_mac.sv
// Combinational unsigned multiply-add feeding the PE accumulator.
// Build with OSPE_SAT_EN for a saturating add; the default build wraps.
module ospe_mac
   import ospe_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ACC_W  = ACC_W_DEF
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [ACC_W-1:0]  acc,
   output logic [ACC_W-1:0]  accNext_c
);

   // Wide enough for the full product and for any accumulator width.
   localparam int unsigned PW = (2 * DATA_W > ACC_W) ? 2 * DATA_W : ACC_W;

`ifdef OSPE_SAT_EN
   logic [PW-1:0]    prodFull;
   logic [ACC_W-1:0] prodLo;
   logic             prodHiNz;
   logic [ACC_W:0]   sumExt;

   always_comb begin
      prodFull  = PW'(a) * PW'(b);
      prodLo    = prodFull[ACC_W-1:0];
      prodHiNz  = |(prodFull >> ACC_W);
      sumExt    = {1'b0, acc} + {1'b0, prodLo};
      accNext_c = sumExt[ACC_W-1:0];
      // Any carry out or discarded product bit pins the sum at full scale.
      if (sumExt[ACC_W] || prodHiNz) begin
         accNext_c = '1;
      end
   end
`else
   logic [ACC_W-1:0] prodLo;

   always_comb begin
      prodLo    = ACC_W'(PW'(a) * PW'(b));
      accNext_c = acc + prodLo;
   end
`endif

endmodule

// File: rtl/os_pe.sv
// Output-stationary systolic PE: forwards operands east/south and keeps a local
// partial sum. Optional saturating accumulation via OSPE_SAT_EN.
module os_pe
   import ospe_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ACC_W  = ACC_W_DEF
) (
   input  logic              clk,
   input  logic              rstnPipe,
   input  logic              rstnPsum,
   input  logic [DATA_W-1:0] ipA,
   input  logic [DATA_W-1:0] ipB,
   output logic [DATA_W-1:0] opA,
   output logic [DATA_W-1:0] opB,
   output logic [ACC_W-1:0]  opC
);

   logic [ACC_W-1:0] accNext;

   // Product uses the live inputs, not the forwarded copies.
   ospe_mac #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) uMac (
      .a         (ipA),
      .b         (ipB),
      .acc       (opC),
      .accNext_c (accNext)
   );

   // Forwarding pipeline; reset names are legacy, both resets are active high.
   always_ff @(posedge clk) begin
      if (rstnPipe) begin
         opA <= '0;
         opB <= '0;
      end else begin
         opA <= ipA;
         opB <= ipB;
      end
   end

   always_ff @(posedge clk) begin
      if (rstnPsum) begin
         opC <= '0;
      end else begin
         opC <= accNext;
      end
   end

endmodule

// File: tb/tb_os_pe.sv
// Self-checking bench for os_pe: directed vector table, hold sequence, random vs model.
module tb_os_pe;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam logic [63:0] MAXV = 64'h0000_0000_FFFF_FFFF;

`ifdef OSPE_SAT_EN
   localparam logic [31:0] OVF_EXP = 32'hFFFF_FFFF;
`else
   localparam logic [31:0] OVF_EXP = 32'h0000_0000;
`endif

   logic          clk;
   logic          rstnPipe;
   logic          rstnPsum;
   logic [DW-1:0] ipA;
   logic [DW-1:0] ipB;
   logic [DW-1:0] opA;
   logic [DW-1:0] opB;
   logic [AW-1:0] opC;

   int checks = 0;
   int errors = 0;

   os_pe #(.DATA_W(DW), .ACC_W(AW)) dut (
      .clk      (clk),
      .rstnPipe (rstnPipe),
      .rstnPsum (rstnPsum),
      .ipA      (ipA),
      .ipB      (ipB),
      .opA      (opA),
      .opB      (opB),
      .opC      (opC)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rp;
      logic        rs;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expA;
      logic [31:0] expB;
      logic [31:0] expC;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rp, input logic rs, input logic [31:0] a, input logic [31:0] b);
      rstnPipe = rp;
      rstnPsum = rs;
      ipA      = a;
      ipB      = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model state for the random phase: spec rules in plain arithmetic.
   logic [31:0] mA, mB, mC;
   logic [63:0] prod, sum;

   initial begin
      drive(1'b1, 1'b1, 32'd0, 32'd0);

      vecs.push_back('{1'b1, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0});
      vecs.push_back('{1'b0, 1'b0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1});
      vecs.push_back('{1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1});
      vecs.push_back('{1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0});
      vecs.push_back('{1'b0, 1'b0, 32'd2, 32'd3, 32'd2, 32'd3, 32'd6});
      vecs.push_back('{1'b0, 1'b0, 32'd4, 32'd5, 32'd4, 32'd5, 32'd26});
      vecs.push_back('{1'b0, 1'b0, 32'd1, 32'd7, 32'd1, 32'd7, 32'd33});
      vecs.push_back('{1'b1, 1'b0, 32'd9, 32'd9, 32'd0, 32'd0, 32'd114});
      vecs.push_back('{1'b0, 1'b1, 32'd3, 32'd4, 32'd3, 32'd4, 32'd0});
      vecs.push_back('{1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF});
      vecs.push_back('{1'b0, 1'b0, 32'd1, 32'd1, 32'd1, 32'd1, OVF_EXP});
      vecs.push_back('{1'b0, 1'b1, 32'd5, 32'd5, 32'd5, 32'd5, 32'd0});
      vecs.push_back('{1'b0, 1'b0, 32'd5, 32'd5, 32'd5, 32'd5, 32'd25});
      vecs.push_back('{1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd25});

      foreach (vecs[i]) begin
         drive(vecs[i].rp, vecs[i].rs, vecs[i].a, vecs[i].b);
         tick();
         chk($sformatf("vec%0d.opA", i), opA, vecs[i].expA);
         chk($sformatf("vec%0d.opB", i), opB, vecs[i].expB);
         chk($sformatf("vec%0d.opC", i), opC, vecs[i].expC);
      end

      // Psum reset held over several edges with live operands keeps opC at zero.
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b1, 32'd7 + 32'(k), 32'd3);
         tick();
         chk($sformatf("hold%0d.opC", k), opC, 32'd0);
         chk($sformatf("hold%0d.opA", k), opA, 32'd7 + 32'(k));
      end
      // First edge after release accumulates from zero.
      drive(1'b0, 1'b0, 32'd6, 32'd7);
      tick();
      chk("release.opC", opC, 32'd42);

      // Large product whose high half is nonzero.
      drive(1'b0, 1'b1, 32'd0, 32'd0);
      tick();
      drive(1'b0, 1'b0, 32'h0001_0000, 32'h0001_0001);
      tick();
`ifdef OSPE_SAT_EN
      chk("bigprod.opC", opC, 32'hFFFF_FFFF);
`else
      chk("bigprod.opC", opC, 32'h0001_0000);
`endif

      // Random phase against the model, both resets first.
      drive(1'b1, 1'b1, 32'd0, 32'd0);
      tick();
      mA = 32'd0;
      mB = 32'd0;
      mC = 32'd0;
      for (int n = 0; n < 400; n++) begin
         logic        rp, rs;
         logic [31:0] a, b;
         rp = ($urandom_range(0, 15) == 0);
         rs = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) begin
            a = $urandom;
            b = $urandom;
         end else begin
            a = 32'($urandom_range(0, 300));
            b = 32'($urandom_range(0, 300));
         end
         drive(rp, rs, a, b);
         tick();
         prod = 64'(a) * 64'(b);
         sum  = 64'(mC) + (prod % (MAXV + 64'd1));
`ifdef OSPE_SAT_EN
         if (prod > MAXV || sum > MAXV) sum = MAXV;
`endif
         mC = rs ? 32'd0 : 32'(sum % (MAXV + 64'd1));
         mA = rp ? 32'd0 : a;
         mB = rp ? 32'd0 : b;
         chk($sformatf("rnd%0d.opA", n), opA, mA);
         chk($sformatf("rnd%0d.opB", n), opB, mB);
         chk($sformatf("rnd%0d.opC", n), opC, mC);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/os_pe.md
Name: os_pe

Overview:
- Output-stationary processing element: one tile of a systolic-array matrix multiplier.
- Operands enter on ipA (from the west) and ipB (from the north).
- Each clock, operands are forwarded one register stage east/south (opA/opB) and their product is added into a local partial-sum accumulator (opC) that stays in the PE.
- Two independent resets: one clears the forwarding pipeline, one clears the partial sum.

Parameters:
- DATA_W, 32, operand width of ipA/ipB/opA/opB.
- ACC_W, 32, accumulator/opC width; must be >= DATA_W.

Ports:
- clk  input  1  rising-edge clock, sole clock domain.
- rstnPipe  input  1  synchronous active-high reset of the forwarding registers opA/opB. Name retained from the codebase; polarity is high.
- rstnPsum  input  1  synchronous active-high reset of the accumulator opC.
- ipA  input  DATA_W  west operand.
- ipB  input  DATA_W  north operand.
- opA  output  DATA_W  registered copy of ipA, to the east neighbour.
- opB  output  DATA_W  registered copy of ipB, to the south neighbour.
- opC  output  ACC_W  accumulated partial sum, registered.

Behaviour:
- All state updates on the rising edge of clk; no asynchronous paths. All outputs driven directly from registers.
- Reset values:
  - rstnPipe=1 at an edge → opA=0, opB=0.
  - rstnPsum=1 at an edge → opC=0.
- Resets are independent:
  - Pipe reset does not touch opC.
  - Psum reset does not touch opA/opB.
  - Both may be asserted together.
- Forwarding (rstnPipe=0): opA <= ipA, opB <= ipB. Latency 1 cycle; no enable or stall.
- Accumulation (rstnPsum=0): opC <= opC + (ipA*ipB).
  - Product uses the current inputs, not opA/opB; result visible 1 cycle after the operands are presented.
  - Multiply is unsigned: full 2*DATA_W product, low ACC_W bits used.
  - Addition wraps modulo 2^ACC_W (default build).
  - Accumulation continues every cycle whether or not rstnPipe is asserted.
  - Zero operands leave opC unchanged.
- Priority: reset over update, per register group.
  - If rstnPsum=1, opC becomes 0 that edge and the current product is discarded, not loaded.
- Reset mid-operation: assertion for one cycle is sufficient; the next non-reset edge resumes normal update from the zero state.
- Out-of-reset state before the first reset is unspecified. Benches must apply both resets first.

Optional Feature:
- Macro OSPE_SAT_EN.
- Defined:
  - Accumulator add is saturating unsigned: if opC + product (product truncated to ACC_W) exceeds 2^ACC_W-1, opC <= 2^ACC_W-1 and holds there until rstnPsum.
  - Product bits above ACC_W that are nonzero also force saturation.
- Undefined: wrap-around modulo 2^ACC_W as above.
- Port list identical in both builds.

Decomposition:
- Shared package ospe_pkg:
  - default widths DATA_W_DEF=32, ACC_W_DEF=32.
  - typedefs data_t [DATA_W-1:0] and acc_t [ACC_W-1:0] for array-level reuse.
- One natural sub-module, ospe_mac: combinational multiply-add (plus saturation under OSPE_SAT_EN) feeding the opC register.
- Forwarding registers stay in the top module.

Test Plan:
- Both resets high for 1 cycle → opA=0, opB=0, opC=0.
- Resets low; ipA=1, ipB=1 for one cycle, then 0,0 → next cycle opA=1, opB=1, opC=1; following cycle opA=0, opB=0, opC stays 1.
- Stream (ipA,ipB) = (2,3),(4,5),(1,7) → opC sequence 6, 26, 33, each one cycle after its operands; opA/opB echo inputs with 1-cycle delay.
- rstnPipe=1 alone while ipA=9, ipB=9 → opA=opB=0 next edge, opC increases by 81; rstnPsum=1 alone → opC=0 while opA/opB keep forwarding.
- Overflow: opC=0xFFFFFFFF (preloaded via ipA=0xFFFFFFFF, ipB=1), then (1,1):
  - default build → opC=0x00000000.
  - OSPE_SAT_EN build → opC=0xFFFFFFFF.
- Simultaneous rstnPsum=1 with ipA=5, ipB=5 → opC=0, not 25; next cycle (5,5) with reset low → opC=25.
